// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register file port arbiter.
// Holds the arbiter state encoding and default widths.
package regfile_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int ZERO_REG   = 0;

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      STALL,
      RESP
   } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter_starvation_counter.sv
// Counts blocked arbitration cycles for a pending debug request.
// Ports: clear_i, inc_i in; hit_o high when count reaches MAX_WAIT-1.
module starvation_counter #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign hit_o = (cnt_q == LAST);

   // Holds at LAST instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (inc_i && !hit_o)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file ports between the core and a debug requester.
// Core side: core_*; debug side: dbg_*; register file side: rf_*.
module regfile_port_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_rd_en,
   input  logic [ADDR_W-1:0] core_a1,
   input  logic [ADDR_W-1:0] core_a2,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_a3,
   input  logic [DATA_W-1:0] core_wd,
   output logic [DATA_W-1:0] core_rd1,
   output logic [DATA_W-1:0] core_rd2,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] rf_a1,
   output logic [ADDR_W-1:0] rf_a2,
   output logic [ADDR_W-1:0] rf_a3,
   output logic              rf_we3,
   output logic [DATA_W-1:0] rf_wd3,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              busy;
   logic              access;
   logic              hit;

   // The port the debug access needs is the one the core may occupy.
   assign busy   = dbg_we ? core_we : core_rd_en;
   assign access = (state_q == STALL) ||
                   ((state_q == ARB) && dbg_req && !busy);

   starvation_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (state_q == IDLE),
      .inc_i   ((state_q == ARB) && dbg_req && busy),
      .hit_o   (hit)
   );

   assign rf_a2      = core_a2;
   assign core_rd1   = rf_rd1;
   assign core_rd2   = rf_rd2;
   assign core_stall = (state_q == STALL);
   assign dbg_gnt    = access;
   assign dbg_rvalid = (state_q == RESP);
   assign dbg_rdata  = rdata_q;

   always_comb begin
      rf_a1  = core_a1;
      rf_a3  = core_a3;
      rf_wd3 = core_wd;
      rf_we3 = core_we;
      if (access && !dbg_we)
         rf_a1 = dbg_addr;
      if (access && dbg_we) begin
         rf_a3  = dbg_addr;
         rf_wd3 = dbg_wdata;
         rf_we3 = (dbg_addr != ADDR_W'(ZERO_REG));
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (access && !dbg_we)
         rdata_d = rf_rd1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (dbg_req) state_d = ARB;
         ARB: begin
            if (!dbg_req)
               state_d = IDLE;
            else if (!busy)
               state_d = dbg_we ? IDLE : RESP;
            else if (hit)
               state_d = STALL;
         end
         STALL: state_d = dbg_we ? IDLE : RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
